// File: rtl/can_eof_tx_if.sv
// Bus-side signal bundle of the CAN transmit trailer generator.
//   master : the bit-timing / protocol controller (drives sp, rx, start, abort)
//   slave  : can_eof_tx (drives tx, busy, done and the status pulses)
interface can_eof_tx_if;
  logic sp;          // sample-point strobe, one clock wide per CAN bit
  logic rx;          // bus readback, 0 = dominant
  logic start;       // one-clock request to begin the trailer
  logic abort;       // synchronous abort
  logic tx;          // bit driven to the transceiver, 0 = dominant
  logic busy;        // high whenever the trailer generator is not idle
  logic done;        // trailer completed or terminated
  logic ack_error;   // recessive readback in the ACK slot
  logic form_error;  // dominant readback in a fixed-form recessive bit
  logic overload;    // dominant readback in last EOF bit or early intermission

  modport master (
    output sp, rx, start, abort,
    input  tx, busy, done, ack_error, form_error, overload
  );

  modport slave (
    input  sp, rx, start, abort,
    output tx, busy, done, ack_error, form_error, overload
  );
endinterface

// File: rtl/can_eof_tx.sv
// CAN transmit-side frame trailer generator: after the last CRC bit it drives
// CRC delimiter, ACK slot, ACK delimiter, EOF and intermission, reads the bus
// back on every sample point and reports ack/form/overload conditions.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : can_eof_tx_if.slave (sp, rx, start, abort in; tx, busy, done,
//           ack_error, form_error, overload out, all registered)
// Optional feature: define CAN_EOF_TX_ERRFLAG_EN to send an active error flag
// (6 dominant bits) and error delimiter (8 recessive bits) after an error.
module can_eof_tx #(
  parameter int unsigned EOF_BITS = 7,
  parameter int unsigned IFS_BITS = 3,
  parameter int unsigned CNT_W    = 4
) (
  input logic         clock,
  input logic         reset,
  can_eof_tx_if.slave bus
);

  localparam logic [CNT_W-1:0] EOF_LAST = CNT_W'(EOF_BITS - 1);
  localparam logic [CNT_W-1:0] IFS_LAST = CNT_W'(IFS_BITS - 1);
`ifdef CAN_EOF_TX_ERRFLAG_EN
  localparam int unsigned      FLAG_BITS = 6;
  localparam int unsigned      DEL_BITS  = 8;
  localparam logic [CNT_W-1:0] FLAG_LAST = CNT_W'(FLAG_BITS - 1);
  localparam logic [CNT_W-1:0] DEL_LAST  = CNT_W'(DEL_BITS - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    CRC_DEL,
    ACK_SLOT,
    ACK_DEL,
    EOF,
    IFS
`ifdef CAN_EOF_TX_ERRFLAG_EN
    ,
    ERR_FLAG,
    ERR_DEL
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_q, busy_q, done_q, ack_q, form_q, ovl_q;
  logic             done_d, ack_d, form_d, ovl_d, err;

  // Saturating increment so the bit counter can never wrap.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      form_q  <= 1'b0;
      ovl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef CAN_EOF_TX_ERRFLAG_EN
      tx_q    <= (state_d != ERR_FLAG);
`else
      tx_q    <= 1'b1;
`endif
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
      ack_q   <= ack_d;
      form_q  <= form_d;
      ovl_q   <= ovl_d;
    end
  end

  // Next-state and pulse decode; bus bits are judged only on sample points.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ack_d   = 1'b0;
    form_d  = 1'b0;
    ovl_d   = 1'b0;
    err     = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = CRC_DEL;
            cnt_d   = '0;
          end
        end
        CRC_DEL: begin
          if (bus.sp) begin
            if (!bus.rx) begin
              form_d = 1'b1;
              err    = 1'b1;
            end else begin
              state_d = ACK_SLOT;
            end
          end
        end
        ACK_SLOT: begin
          if (bus.sp) begin
            if (bus.rx) begin
              ack_d = 1'b1;
              err   = 1'b1;
            end else begin
              state_d = ACK_DEL;
            end
          end
        end
        ACK_DEL: begin
          if (bus.sp) begin
            if (!bus.rx) begin
              form_d = 1'b1;
              err    = 1'b1;
            end else begin
              state_d = EOF;
              cnt_d   = '0;
            end
          end
        end
        EOF: begin
          if (cnt_q > EOF_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (bus.sp) begin
            // Dominant in the last EOF bit is an overload, not a frame error.
            if (!bus.rx && cnt_q != EOF_LAST) begin
              form_d = 1'b1;
              err    = 1'b1;
            end else begin
              ovl_d = !bus.rx;
              if (cnt_q == EOF_LAST) begin
                state_d = IFS;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_inc(cnt_q);
              end
            end
          end
        end
        IFS: begin
          if (cnt_q > IFS_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (bus.sp) begin
            // Dominant in the last intermission bit is a new SOF, not overload.
            if (cnt_q == IFS_LAST || !bus.rx) begin
              ovl_d   = !bus.rx && (cnt_q != IFS_LAST);
              done_d  = 1'b1;
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc(cnt_q);
            end
          end
        end
`ifdef CAN_EOF_TX_ERRFLAG_EN
        ERR_FLAG: begin
          if (cnt_q > FLAG_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (bus.sp) begin
            if (cnt_q == FLAG_LAST) begin
              state_d = ERR_DEL;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc(cnt_q);
            end
          end
        end
        ERR_DEL: begin
          if (cnt_q > DEL_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (bus.sp) begin
            if (cnt_q == DEL_LAST) begin
              done_d  = 1'b1;
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc(cnt_q);
            end
          end
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      // Common error exit.
      if (err) begin
`ifdef CAN_EOF_TX_ERRFLAG_EN
        state_d = ERR_FLAG;
        cnt_d   = '0;
`else
        state_d = IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
`endif
      end
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.ack_error  = ack_q;
  assign bus.form_error = form_q;
  assign bus.overload   = ovl_q;

endmodule
